// File: rtl/axis_capture_pkg.sv
// Shared types and helpers for the AXI4-Stream frame capture sink.
package axis_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    SKIP,
    CAPTURE,
    DONE
  } cap_state_t;

  // A request of 0, or one larger than the RAM holds, means "fill the RAM".
  function automatic int unsigned clamp_frames(input int unsigned req,
                                               input int unsigned max_frames);
    return (req == 0 || req > max_frames) ? max_frames : req;
  endfunction

endpackage

// File: rtl/axis_frame_capture_if.sv
// AXI4-Stream bundle feeding the capture sink.
interface axis_frame_capture_if #(
  parameter int unsigned DATA_WID = 32
);
  logic [DATA_WID-1:0] tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/capture_sdp_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module capture_sdp_ram #(
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned DEPTH    = 256,
  localparam int unsigned ADDR_WID = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_WID-1:0] wr_addr,
  input  logic [DATA_WID-1:0] wr_data,
  input  logic [ADDR_WID-1:0] rd_addr,
  output logic [DATA_WID-1:0] rd_data
);

  logic [DATA_WID-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-during-write to the same address returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_frame_capture.sv
// Captures a programmable number of whole tlast-aligned frames after an arm pulse,
// with optional frame skipping and frame-length checking.
module axis_frame_capture
  import axis_capture_pkg::*;
#(
  parameter int unsigned DATA_WID   = 32,
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned MAX_FRAMES = 4,
  parameter int unsigned CNT_WID    = 8,
  parameter int unsigned ALIGN      = 1,
  localparam int unsigned ADDR_WID  = $clog2(FRAME_LEN * MAX_FRAMES)
) (
  input  logic                clk,
  input  logic                rst,
  axis_frame_capture_if.slave s_axis,
  input  logic                arm,
  input  logic [CNT_WID-1:0]  num_frames,
  input  logic [CNT_WID-1:0]  skip_frames,
  input  logic [ADDR_WID-1:0] rd_addr,
  output logic [DATA_WID-1:0] rd_data,
  output logic                capturing,
  output logic                full,
  output logic [CNT_WID-1:0]  frames_done,
  output logic                tlast_err
);

  localparam int unsigned IDX_WID = $clog2(FRAME_LEN);

  cap_state_t          state_q, state_d;
  logic [CNT_WID-1:0]  num_q, num_d;
  logic [CNT_WID-1:0]  skip_q, skip_d;
  logic [CNT_WID-1:0]  frames_done_q, frames_done_d;
  logic [IDX_WID-1:0]  idx_q, idx_d;
  logic                tlast_err_q, tlast_err_d;
  logic                full_q, full_d;
  logic                tready_q;

  logic                beat, last_idx, early_last, frame_end;
  logic                wr_en;
  logic [ADDR_WID-1:0] wr_addr;

  assign beat       = s_axis.tvalid & tready_q;
  assign last_idx   = (idx_q == IDX_WID'(FRAME_LEN - 1));
  assign early_last = beat & s_axis.tlast & ~last_idx;
  assign frame_end  = beat & last_idx;

  // Write pointer is the frame base plus the beat index, so an early tlast rewinds it.
  assign wr_addr = ADDR_WID'(32'(frames_done_q) * FRAME_LEN) + ADDR_WID'(idx_q);

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    skip_d        = skip_q;
    frames_done_d = frames_done_q;
    idx_d         = idx_q;
    tlast_err_d   = tlast_err_q;
    full_d        = full_q;
    wr_en         = 1'b0;

    // Arm wins over any coincident beat, in every state.
    if (arm) begin
      num_d         = CNT_WID'(clamp_frames(32'(num_frames), MAX_FRAMES));
      skip_d        = skip_frames;
      frames_done_d = '0;
      tlast_err_d   = 1'b0;
      full_d        = 1'b0;
      idx_d         = '0;
      if (ALIGN != 0) begin
        state_d = WAIT_SOF;
      end else begin
        state_d = (skip_frames != '0) ? SKIP : CAPTURE;
      end
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_SOF: begin
          if (beat && s_axis.tlast) begin
            idx_d   = '0;
            state_d = (skip_q != '0) ? SKIP : CAPTURE;
          end
        end
        SKIP: begin
          if (beat) begin
            idx_d = idx_q + 1'b1;
            if (early_last) begin
              idx_d       = '0;
              tlast_err_d = 1'b1;
            end else if (frame_end) begin
              if (!s_axis.tlast) tlast_err_d = 1'b1;
              skip_d = skip_q - 1'b1;
              if (skip_q == CNT_WID'(1)) state_d = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (beat) begin
            wr_en = 1'b1;
            idx_d = idx_q + 1'b1;
            if (early_last) begin
              idx_d       = '0;
              tlast_err_d = 1'b1;
            end else if (frame_end) begin
              if (!s_axis.tlast) tlast_err_d = 1'b1;
              frames_done_d = frames_done_q + 1'b1;
              if (frames_done_d == num_q) begin
                state_d = DONE;
                full_d  = 1'b1;
              end
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      num_q         <= '0;
      skip_q        <= '0;
      frames_done_q <= '0;
      idx_q         <= '0;
      tlast_err_q   <= 1'b0;
      full_q        <= 1'b0;
      tready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      skip_q        <= skip_d;
      frames_done_q <= frames_done_d;
      idx_q         <= idx_d;
      tlast_err_q   <= tlast_err_d;
      full_q        <= full_d;
      tready_q      <= 1'b1;
    end
  end

  capture_sdp_ram #(
    .DATA_WID (DATA_WID),
    .DEPTH    (FRAME_LEN * MAX_FRAMES)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (s_axis.tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign s_axis.tready = tready_q;
  assign capturing     = (state_q == WAIT_SOF) || (state_q == SKIP) || (state_q == CAPTURE);
  assign full          = full_q;
  assign frames_done   = frames_done_q;
  assign tlast_err     = tlast_err_q;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture (FRAME_LEN=64, MAX_FRAMES=4, ALIGN=1).
module tb_axis_frame_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic [7:0]  num_frames;
  logic [7:0]  skip_frames;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        capturing;
  logic        full;
  logic [7:0]  frames_done;
  logic        tlast_err;

  int n_vec = 0;
  int n_err = 0;

  axis_frame_capture_if #(.DATA_WID(32)) s_axis ();

  axis_frame_capture #(
    .DATA_WID   (32),
    .FRAME_LEN  (64),
    .MAX_FRAMES (4),
    .CNT_WID    (8),
    .ALIGN      (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_axis),
    .arm         (arm),
    .num_frames  (num_frames),
    .skip_frames (skip_frames),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .capturing   (capturing),
    .full        (full),
    .frames_done (frames_done),
    .tlast_err   (tlast_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input int tag, input int idx);
    return 32'((tag << 16) | idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = l;
    tick();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic send_beats(input int tag, input int from, input int to, input int last_at,
                            input bit gap);
    for (int i = from; i <= to; i++) begin
      beat(dat(tag, i), i == last_at);
      if (gap) tick();
    end
  endtask

  task automatic do_arm(input int n, input int s);
    num_frames  = 8'(n);
    skip_frames = 8'(s);
    arm         = 1'b1;
    tick();
  endtask

  task automatic rd_check(input string tag, input int a, input logic [31:0] exp);
    rd_addr = 8'(a);
    tick();
    check(tag, rd_data, exp);
  endtask

  initial begin
    rst           = 1'b1;
    arm           = 1'b0;
    num_frames    = '0;
    skip_frames   = '0;
    rd_addr       = '0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) tick();

    check("rst_tready", 32'(s_axis.tready), 32'd0);
    check("rst_capturing", 32'(capturing), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_frames_done", 32'(frames_done), 32'd0);
    check("rst_tlast_err", 32'(tlast_err), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    tick();
    check("tready_after_rst", 32'(s_axis.tready), 32'd1);

    // Two frames, armed mid-frame on a coincident beat.
    send_beats(0, 0, 9, -1, 0);
    arm = 1'b1;
    num_frames = 8'd2;
    skip_frames = 8'd0;
    beat(dat(0, 10), 1'b0);
    check("t1_capturing", 32'(capturing), 32'd1);
    send_beats(0, 11, 63, 63, 0);
    send_beats(1, 0, 63, 63, 0);
    check("t1_frames_done_1", 32'(frames_done), 32'd1);
    send_beats(2, 0, 62, 63, 0);
    check("t1_full_before_last", 32'(full), 32'd0);
    beat(dat(2, 63), 1'b1);
    check("t1_full", 32'(full), 32'd1);
    check("t1_frames_done", 32'(frames_done), 32'd2);
    check("t1_capturing_done", 32'(capturing), 32'd0);
    beat(dat(3, 0), 1'b0);
    rd_check("t1_ram0", 0, dat(1, 0));
    rd_check("t1_ram64", 64, dat(2, 0));
    rd_check("t1_ram127", 127, dat(2, 63));
    check("t1_tlast_err", 32'(tlast_err), 32'd0);

    // Skip three frames, store one.
    do_arm(1, 3);
    check("t2_full_cleared", 32'(full), 32'd0);
    send_beats(16, 60, 63, 63, 0);
    send_beats(17, 0, 63, 63, 0);
    send_beats(18, 0, 63, 63, 0);
    send_beats(19, 0, 63, 63, 0);
    check("t2_frames_done_skip", 32'(frames_done), 32'd0);
    check("t2_full_skip", 32'(full), 32'd0);
    send_beats(20, 0, 63, 63, 0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_frames_done", 32'(frames_done), 32'd1);
    rd_check("t2_ram0", 0, dat(20, 0));
    rd_check("t2_ram63", 63, dat(20, 63));
    rd_check("t2_ram64_kept", 64, dat(2, 0));

    // 50% tvalid duty.
    do_arm(1, 0);
    send_beats(32, 62, 63, 63, 0);
    send_beats(33, 0, 62, 63, 1);
    check("t3_tready", 32'(s_axis.tready), 32'd1);
    check("t3_full_early", 32'(full), 32'd0);
    beat(dat(33, 63), 1'b1);
    check("t3_full", 32'(full), 32'd1);
    rd_check("t3_ram5", 5, dat(33, 5));
    rd_check("t3_ram63", 63, dat(33, 63));

    // Early tlast at index 40.
    do_arm(1, 0);
    send_beats(48, 63, 63, 63, 0);
    send_beats(49, 0, 40, 40, 0);
    check("t4_tlast_err", 32'(tlast_err), 32'd1);
    check("t4_frames_done", 32'(frames_done), 32'd0);
    send_beats(50, 0, 63, 63, 0);
    check("t4_full", 32'(full), 32'd1);
    check("t4_frames_done_1", 32'(frames_done), 32'd1);
    rd_check("t4_ram0", 0, dat(50, 0));
    rd_check("t4_ram40", 40, dat(50, 40));
    rd_check("t4_ram41", 41, dat(50, 41));

    // num_frames=0 fills the RAM; one frame lacks tlast.
    do_arm(0, 0);
    check("t5_err_cleared", 32'(tlast_err), 32'd0);
    send_beats(64, 63, 63, 63, 0);
    send_beats(65, 0, 63, 63, 0);
    send_beats(66, 0, 63, -1, 0);
    check("t5_missing_tlast", 32'(tlast_err), 32'd1);
    check("t5_frames_done_2", 32'(frames_done), 32'd2);
    send_beats(67, 0, 63, 63, 0);
    send_beats(68, 0, 63, 63, 0);
    check("t5_frames_done", 32'(frames_done), 32'd4);
    check("t5_full", 32'(full), 32'd1);
    rd_check("t5_ram70", 70, dat(66, 6));
    rd_check("t5_ram192", 192, dat(68, 0));
    rd_check("t5_ram255", 255, dat(68, 63));
    do_arm(1, 0);
    check("t5_rearm_err", 32'(tlast_err), 32'd0);
    check("t5_rearm_full", 32'(full), 32'd0);
    check("t5_rearm_frames", 32'(frames_done), 32'd0);

    // Reset in the middle of a capture.
    send_beats(80, 63, 63, 63, 0);
    send_beats(81, 0, 29, 63, 0);
    rst = 1'b1;
    beat(dat(81, 30), 1'b0);
    check("t6_capturing", 32'(capturing), 32'd0);
    check("t6_tready", 32'(s_axis.tready), 32'd0);
    check("t6_full", 32'(full), 32'd0);
    check("t6_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    tick();
    check("t6_tready_back", 32'(s_axis.tready), 32'd1);
    do_arm(1, 0);
    send_beats(82, 63, 63, 63, 0);
    send_beats(83, 0, 63, 63, 0);
    check("t6_full_again", 32'(full), 32'd1);
    check("t6_frames_done", 32'(frames_done), 32'd1);
    rd_check("t6_ram30", 30, dat(83, 30));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
